vector_result_unloader: RTL and testbench
=========================================

// Module: vector_result_unloader
// PURPOSE
//  Consumer side of the vector adder's parallel result bus.
//  On start it drives the adder enable for a fixed FPU latency, then snapshots the LENGTH-wide result vector.
//  It then streams the elements out one per handshake on a valid/ready scalar port, index 0 first.
//  Sits between the per-lane FP adder array and the serial writeback/activation path.
// PARAMETERS
//  DATA_WIDTH   16  bits per element (FP16 word, passed through untouched)
//  LENGTH       4   elements per vector (>=1)
//  FPU_LATENCY  3   cycles from adder enable to valid result on vec_in (>=1)
// PORTS
//  clk        in   1                    clock, all state updates on rising edge
//  reset      in   1                    synchronous, active-high reset
//  start      in   1                    request one add+unload; sampled only in IDLE
//  add_en     out  1                    enable to the adder lanes; high only in WAIT
//  vec_in     in   DATA_WIDTH x LENGTH  adder result vector, [DATA_WIDTH-1:0] vec_in [0:LENGTH-1]
//  out_data   out  DATA_WIDTH           current streamed element
//  out_valid  out  1                    out_data valid
//  out_ready  in   1                    downstream accepts when high together with out_valid
//  out_last   out  1                    high with out_valid on element LENGTH-1
//  busy       out  1                    state != IDLE
//  done       out  1                    one-cycle pulse after the last element is accepted
// BEHAVIOUR
//  Reset:
//   - state=IDLE; idx=0; lat_cnt=0; buffer cleared to 0.
//   - add_en, out_valid, out_last, busy, done = 0; out_data = 0.
//   - Reset asserted in any state aborts the operation with no done pulse; sampled-high reset wins over all inputs.
//  FSM: IDLE -> WAIT -> STREAM -> IDLE.
//   IDLE:
//    - start=1 -> WAIT with lat_cnt=0.
//    - start ignored in every other state (no queueing).
//   WAIT:
//    - add_en=1; lat_cnt increments each cycle.
//    - At the edge where lat_cnt==FPU_LATENCY-1: latch all vec_in[i] into buffer[i], set idx=0, go to STREAM.
//    - vec_in is don't-care at every other edge.
//   STREAM:
//    - out_valid=1; out_data=buffer[idx]; out_last=(idx==LENGTH-1).
//    - Handshake on out_valid & out_ready at a rising edge:
//      - not last -> idx+1.
//      - last -> IDLE; done=1 for the next cycle only.
//    - out_ready low: out_data, out_last and idx are held stable; no timeout.
//    - vec_in changes during STREAM have no effect (snapshot only).
//  done/start overlap: done cycle is an IDLE cycle, so a start in that cycle is accepted; back-to-back runs have no dead cycle.
//  Outputs are functions of registered state only; no combinational path from out_ready or start to any output.
//  LENGTH=1: first element carries out_last.
//  Width rules:
//   - idx is $clog2(LENGTH) bits (min 1); lat_cnt is $clog2(FPU_LATENCY) bits (min 1).
//   - Data is not modified, sign-extended or rounded.
//  Timing (out_ready held 1), start sampled at edge E:
//   - add_en high cycles E+1..E+FPU_LATENCY.
//   - out_valid cycles E+FPU_LATENCY+1 .. E+FPU_LATENCY+LENGTH.
//   - done in cycle E+FPU_LATENCY+LENGTH+1.
// TESTING
//  T1 basic (defaults):
//   - Stimulus: start 1 cycle; vec_in={3C00,4000,4200,4400} at capture; out_ready=1.
//   - Response: add_en 3 cycles; out_data 3C00,4000,4200,4400 on 4 consecutive cycles; out_last on 4400; done 8 cycles after start.
//  T2 backpressure:
//   - Stimulus: as T1; out_ready low 2 cycles on element 1.
//   - Response: out_data=4000 and out_valid held for 3 cycles; no element lost or duplicated; done 2 cycles later than T1.
//  T3 snapshot:
//   - Stimulus: change vec_in to all 7BFF during STREAM.
//   - Response: streamed values still 3C00,4000,4200,4400.
//  T4 ignored start and back-to-back:
//   - Stimulus: pulse start during WAIT and STREAM; then start in the done cycle.
//   - Response: the mid-run pulses have no effect; the second run's add_en rises the next cycle.
//  T5 reset mid-STREAM:
//   - Stimulus: assert reset after element 1 is accepted.
//   - Response: next cycle all outputs 0, busy=0, no done pulse; a following start runs a clean full sequence from element 0.
//  T6 corner (LENGTH=1, FPU_LATENCY=1):
//   - Response: add_en 1 cycle; single element with out_last=1; done 3 cycles after start.

Source files
------------

// File: rtl/vector_result_unloader.sv
// Consumer side of the vector adder result bus: enables the adder for a fixed
// latency, snapshots the result vector, then streams it out on a valid/ready port.
module vector_result_unloader #(
  parameter int DATA_WIDTH  = 16,
  parameter int LENGTH      = 4,
  parameter int FPU_LATENCY = 3
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  output logic                  add_en,
  input  logic [DATA_WIDTH-1:0] vec_in [0:LENGTH-1],
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  out_last,
  output logic                  busy,
  output logic                  done
);

  localparam int IW = (LENGTH > 1) ? $clog2(LENGTH) : 1;
  localparam int LW = (FPU_LATENCY > 1) ? $clog2(FPU_LATENCY) : 1;
  localparam logic [IW-1:0] IDX_LAST = IW'(LENGTH - 1);
  localparam logic [LW-1:0] LAT_LAST = LW'(FPU_LATENCY - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    WAIT   = 2'd1,
    STREAM = 2'd2
  } state_t;

  state_t                  state;
  state_t                  state_next;
  logic [LW-1:0]           lat_cnt;
  logic [IW-1:0]           idx;
  logic [DATA_WIDTH-1:0]   buffer [0:LENGTH-1];
  logic                    done_r;
  logic                    capture;
  logic                    accept;
  logic                    accept_last;

  assign capture     = (state == WAIT) && (lat_cnt == LAT_LAST);
  assign accept      = (state == STREAM) && out_ready;
  assign accept_last = accept && (idx == IDX_LAST);

  // Next-state selection
  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (start) state_next = WAIT;
        else       state_next = IDLE;
      end
      WAIT: begin
        if (capture) state_next = STREAM;
        else         state_next = WAIT;
      end
      STREAM: begin
        if (accept_last) state_next = IDLE;
        else             state_next = STREAM;
      end
      default: state_next = IDLE;
    endcase
  end

  // State, counters, snapshot buffer and done flag
  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      lat_cnt <= '0;
      idx     <= '0;
      done_r  <= 1'b0;
      for (int i = 0; i < LENGTH; i++) buffer[i] <= '0;
    end else begin
      state  <= state_next;
      done_r <= accept_last;
      case (state)
        IDLE: begin
          lat_cnt <= '0;
        end
        WAIT: begin
          lat_cnt <= lat_cnt + LW'(1);
          if (capture) begin
            // vec_in is only meaningful at this one edge
            for (int i = 0; i < LENGTH; i++) buffer[i] <= vec_in[i];
            idx <= '0;
          end
        end
        STREAM: begin
          if (accept && !accept_last) idx <= idx + IW'(1);
        end
        default: begin
          lat_cnt <= '0;
          idx     <= '0;
        end
      endcase
    end
  end

  // Output decode from registered state only
  always_comb begin
    add_en    = 1'b0;
    out_valid = 1'b0;
    out_last  = 1'b0;
    out_data  = '0;
    busy      = (state != IDLE);
    done      = done_r;
    case (state)
      WAIT: begin
        add_en = 1'b1;
      end
      STREAM: begin
        out_valid = 1'b1;
        out_data  = buffer[idx];
        out_last  = (idx == IDX_LAST);
      end
      default: begin
        add_en    = 1'b0;
        out_valid = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_vector_result_unloader.sv
// Directed bench for vector_result_unloader: default configuration plus a
// LENGTH=1 / FPU_LATENCY=1 corner instance sharing clock and reset.
module tb_vector_result_unloader;

  logic        clk = 1'b0;
  logic        reset;
  logic        start, start1;
  logic        add_en, add_en1;
  logic [15:0] vec [0:3];
  logic [15:0] vec1 [0:0];
  logic [15:0] out_data, out_data1;
  logic        out_valid, out_valid1;
  logic        out_ready, out_ready1;
  logic        out_last, out_last1;
  logic        busy, busy1;
  logic        done, done1;

  logic [15:0] exp_data [0:3];
  int          n_tests = 0;
  int          n_fail  = 0;

  always #5 clk = ~clk;

  vector_result_unloader #(.DATA_WIDTH(16), .LENGTH(4), .FPU_LATENCY(3)) dut (
    .clk(clk), .reset(reset), .start(start), .add_en(add_en), .vec_in(vec),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .out_last(out_last), .busy(busy), .done(done)
  );

  vector_result_unloader #(.DATA_WIDTH(16), .LENGTH(1), .FPU_LATENCY(1)) dut1 (
    .clk(clk), .reset(reset), .start(start1), .add_en(add_en1), .vec_in(vec1),
    .out_data(out_data1), .out_valid(out_valid1), .out_ready(out_ready1),
    .out_last(out_last1), .busy(busy1), .done(done1)
  );

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_tests++;
    if (obs !== exp_v) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp_v, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load_vec();
    for (int i = 0; i < 4; i++) vec[i] = exp_data[i];
  endtask

  task automatic check_idle(input string tag);
    check_eq({tag, "_add_en"},    32'(add_en),    32'd0);
    check_eq({tag, "_out_valid"}, 32'(out_valid), 32'd0);
    check_eq({tag, "_out_last"},  32'(out_last),  32'd0);
    check_eq({tag, "_busy"},      32'(busy),      32'd0);
    check_eq({tag, "_out_data"},  32'(out_data),  32'd0);
  endtask

  // One full run; 'started' means the start edge is already behind us.
  task automatic do_run(input string tag, input bit started, input int stall_elem,
                        input int stall_n, input bit corrupt, input bit mid_pulse,
                        input bit start_at_done);
    if (!started) begin
      start = 1'b1;
      tick();
      start = 1'b0;
    end
    for (int i = 0; i < 3; i++) begin
      check_eq({tag, "_wait_add_en"}, 32'(add_en),    32'd1);
      check_eq({tag, "_wait_busy"},   32'(busy),      32'd1);
      check_eq({tag, "_wait_valid"},  32'(out_valid), 32'd0);
      start = mid_pulse && (i == 1);
      tick();
      start = 1'b0;
    end
    for (int i = 0; i < 4; i++) begin
      if (i == stall_elem) begin
        for (int s = 0; s < stall_n; s++) begin
          out_ready = 1'b0;
          check_eq({tag, "_stall_valid"}, 32'(out_valid), 32'd1);
          check_eq({tag, "_stall_data"},  32'(out_data),  32'(exp_data[i]));
          check_eq({tag, "_stall_last"},  32'(out_last),  32'(i == 3));
          tick();
        end
      end
      out_ready = 1'b1;
      check_eq({tag, "_valid"},  32'(out_valid), 32'd1);
      check_eq({tag, "_data"},   32'(out_data),  32'(exp_data[i]));
      check_eq({tag, "_last"},   32'(out_last),  32'(i == 3));
      check_eq({tag, "_add_en"}, 32'(add_en),    32'd0);
      check_eq({tag, "_done0"},  32'(done),      32'd0);
      if (corrupt && i == 0) for (int k = 0; k < 4; k++) vec[k] = 16'h7BFF;
      start = mid_pulse && (i == 2);
      tick();
      start = 1'b0;
    end
    check_eq({tag, "_done"},       32'(done),      32'd1);
    check_eq({tag, "_done_busy"},  32'(busy),      32'd0);
    check_eq({tag, "_done_valid"}, 32'(out_valid), 32'd0);
    start = start_at_done;
    tick();
    start = 1'b0;
    if (!start_at_done) begin
      check_eq({tag, "_done_pulse"}, 32'(done), 32'd0);
      check_idle({tag, "_after"});
    end
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: bench did not finish, got running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    exp_data[0] = 16'h3C00;
    exp_data[1] = 16'h4000;
    exp_data[2] = 16'h4200;
    exp_data[3] = 16'h4400;
    reset = 1'b1; start = 1'b0; start1 = 1'b0;
    out_ready = 1'b1; out_ready1 = 1'b1;
    load_vec();
    vec1[0] = 16'hABCD;
    tick(); tick();
    reset = 1'b0;
    tick();

    // Reset state
    check_idle("rst");
    check_eq("rst_done", 32'(done), 32'd0);
    check_eq("rst1_valid", 32'(out_valid1), 32'd0);
    check_eq("rst1_busy",  32'(busy1),      32'd0);
    check_eq("rst1_data",  32'(out_data1),  32'd0);

    // T1 basic
    do_run("t1", 1'b0, -1, 0, 1'b0, 1'b0, 1'b0);
    // T2 backpressure on element 1
    do_run("t2", 1'b0, 1, 2, 1'b0, 1'b0, 1'b0);
    // T3 snapshot: vec_in changes during STREAM
    do_run("t3", 1'b0, -1, 0, 1'b1, 1'b0, 1'b0);
    load_vec();
    // T4 ignored mid-run starts, then start in done cycle
    do_run("t4a", 1'b0, -1, 0, 1'b0, 1'b1, 1'b1);
    do_run("t4b", 1'b1, -1, 0, 1'b0, 1'b0, 1'b0);

    // T5 reset after element 1 accepted
    start = 1'b1; tick(); start = 1'b0;
    tick(); tick(); tick();
    check_eq("t5_e0", 32'(out_data), 32'h3C00);
    tick();
    check_eq("t5_e1", 32'(out_data), 32'h4000);
    tick();
    check_eq("t5_e2", 32'(out_data), 32'h4200);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check_idle("t5_rst");
    check_eq("t5_rst_done", 32'(done), 32'd0);
    tick();
    check_eq("t5_no_done", 32'(done), 32'd0);
    do_run("t5_clean", 1'b0, -1, 0, 1'b0, 1'b0, 1'b0);

    // T6 corner LENGTH=1, FPU_LATENCY=1
    start1 = 1'b1; tick(); start1 = 1'b0;
    check_eq("t6_add_en",  32'(add_en1),    32'd1);
    check_eq("t6_valid0",  32'(out_valid1), 32'd0);
    tick();
    check_eq("t6_add_en2", 32'(add_en1),    32'd0);
    check_eq("t6_valid",   32'(out_valid1), 32'd1);
    check_eq("t6_data",    32'(out_data1),  32'hABCD);
    check_eq("t6_last",    32'(out_last1),  32'd1);
    tick();
    check_eq("t6_done",    32'(done1),      32'd1);
    check_eq("t6_valid2",  32'(out_valid1), 32'd0);
    tick();
    check_eq("t6_done2",   32'(done1),      32'd0);
    check_eq("t6_busy",    32'(busy1),      32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
